// File: rtl/kbd_buf_pkg.sv
// Shared types, default sizing and IOBUS addresses for the keyboard scancode buffer.
package kbd_buf_pkg;

  localparam int DEF_DEPTH    = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_INTR_LEN = 4;

  localparam logic [31:0] KEYBOARD_AD      = 32'h11200000;
  localparam logic [31:0] KEYBOARD_ACK_AD  = 32'h11240000;
  localparam logic [31:0] KEYBOARD_STAT_AD = 32'h11280000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } intr_state_t;

endpackage

// File: rtl/kbd_scancode_buffer_ring.sv
// Synchronous scancode FIFO with a registered occupancy counter and sticky drop flag.
module scancode_ring #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push_req,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop_req,
  input  logic                     i_ovf_clr,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_overflow;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);

  // A pop frees the slot in the same edge, so a strobe while full is accepted.
  assign w_push = i_push_req && (!o_full || i_pop_req);
  assign w_pop  = i_pop_req && !o_empty;
  assign w_drop = i_push_req && o_full && !i_pop_req;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A fresh drop outranks a clear in the same cycle.
      if (w_drop)         r_overflow <= 1'b1;
      else if (i_ovf_clr) r_overflow <= 1'b0;
    end
  end

  assign o_data     = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/kbd_scancode_buffer.sv
// Scancode FIFO front-end for the MCU: head-of-queue read data plus a
// fixed-length interrupt pulse that re-fires after each ack while data remains.
module kbd_scancode_buffer
  import kbd_buf_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int INTR_LEN = DEF_INTR_LEN
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   KB_STRB,
  input  logic [DATA_W-1:0]      KB_CODE,
  input  logic                   POP,
  input  logic                   STAT_CLR,
  output logic [DATA_W-1:0]      DATA_OUT,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   EMPTY,
  output logic                   FULL,
  output logic                   OVERFLOW,
  output logic                   INTR
);

  localparam int CNT_W = (INTR_LEN > 1) ? $clog2(INTR_LEN) : 1;

  intr_state_t      r_state;
  logic [CNT_W-1:0] r_pcnt;
  logic             r_pend;
  logic             w_last;

  scancode_ring #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ring (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_push_req (KB_STRB),
    .i_data     (KB_CODE),
    .i_pop_req  (POP),
    .i_ovf_clr  (STAT_CLR),
    .o_data     (DATA_OUT),
    .o_count    (COUNT),
    .o_full     (FULL),
    .o_empty    (EMPTY),
    .o_overflow (OVERFLOW)
  );

  assign w_last = (r_pcnt == CNT_W'(INTR_LEN - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_pcnt  <= '0;
      r_pend  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (COUNT != '0) begin
            r_state <= PULSE;
            r_pcnt  <= '0;
            r_pend  <= 1'b0;
          end
        end
        PULSE: begin
          r_pcnt <= r_pcnt + 1'b1;
          if (POP) r_pend <= 1'b1;
          // An ack already seen during the pulse skips the wait for one.
          if (w_last) r_state <= (r_pend || POP) ? GAP : WAIT;
        end
        WAIT: begin
          if (POP) r_state <= GAP;
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign INTR = (r_state == PULSE);

endmodule
